// File: rtl/address_latch.sv
// Address latch with a one-cycle +/-1 adjuster on the CPU address side.
// Latency: capture or adjust lands in al at edge N and on abus at edge N+1; bus write-back is combinational from al.
// Backpressure: none; the latch takes a control vector every cycle and pins may float on bus grant.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   db_hi_as, db_lo_as         shared address-side bus halves (read on capture, driven on ctl_al_oe)
//   ctl_al_we                  capture the bus into the latch (ignored while ctl_al_oe)
//   ctl_inc_cy, ctl_inc_dec    apply +1 (dec=0) or -1 (dec=1) to the next latch value
//   ctl_inc_limit7             count only bits [6:0] (R-register refresh)
//   ctl_al_oe                  drive the latch onto the address-side bus
//   ctl_bus_float              release the external address pins
//   abus, abus_oe              registered external address pins and their enable
//   al_nz                      latch value is non-zero
module address_latch (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [7:0]  db_lo_as,
    inout  wire  [7:0]  db_hi_as,
    input  logic        ctl_al_we,
    input  logic        ctl_inc_cy,
    input  logic        ctl_inc_dec,
    input  logic        ctl_inc_limit7,
    input  logic        ctl_al_oe,
    input  logic        ctl_bus_float,
    output logic [15:0] abus,
    output logic        abus_oe,
    output logic        al_nz
);

    logic [15:0] al;
    logic [15:0] base;
    logic [15:0] al_next;
    logic [6:0]  low7;

    always_comb begin
        // While we drive the bus ourselves a capture would only read back al,
        // so the write enable is masked and the current value is the base.
        base    = (ctl_al_we && !ctl_al_oe) ? {db_hi_as, db_lo_as} : al;
        al_next = base;
        low7    = base[6:0];
        if (ctl_inc_cy) begin
            if (ctl_inc_limit7) begin
                // Refresh counter: bits [15:7] (including bit 7) are carried through untouched.
                low7    = ctl_inc_dec ? (base[6:0] - 7'd1) : (base[6:0] + 7'd1);
                al_next = {base[15:7], low7};
            end else begin
                al_next = ctl_inc_dec ? (base - 16'd1) : (base + 16'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            al      <= 16'h0000;
            abus    <= 16'h0000;
            abus_oe <= 1'b0;
        end else begin
            al      <= al_next;
            // Pins trail the latch by one edge and keep tracking it while floated.
            abus    <= al;
            abus_oe <= !ctl_bus_float;
        end
    end

    // Write-back reflects the current latch, not the value being computed.
    assign db_hi_as = ctl_al_oe ? al[15:8] : 8'hzz;
    assign db_lo_as = ctl_al_oe ? al[7:0]  : 8'hzz;

    assign al_nz = |al;

endmodule

// File: tb/tb_address_latch.sv
// Randomized plus directed bench for address_latch against an arithmetic reference model.
// Latency: one control vector per clock, outputs checked on the falling edge after each rising edge.
// Backpressure: none; the bench drives the shared bus only while the latch is not driving it.
module tb_address_latch;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctl_al_we, ctl_inc_cy, ctl_inc_dec, ctl_inc_limit7, ctl_al_oe, ctl_bus_float;
    logic [15:0] abus;
    logic        abus_oe;
    logic        al_nz;

    logic        tb_drv;
    logic [15:0] tb_val;
    wire  [7:0]  db_hi_as;
    wire  [7:0]  db_lo_as;

    assign db_hi_as = tb_drv ? tb_val[15:8] : 8'hzz;
    assign db_lo_as = tb_drv ? tb_val[7:0]  : 8'hzz;

    address_latch dut (
        .clk            (clk),
        .reset          (reset),
        .db_lo_as       (db_lo_as),
        .db_hi_as       (db_hi_as),
        .ctl_al_we      (ctl_al_we),
        .ctl_inc_cy     (ctl_inc_cy),
        .ctl_inc_dec    (ctl_inc_dec),
        .ctl_inc_limit7 (ctl_inc_limit7),
        .ctl_al_oe      (ctl_al_oe),
        .ctl_bus_float  (ctl_bus_float),
        .abus           (abus),
        .abus_oe        (abus_oe),
        .al_nz          (al_nz)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: the latch value and the value the pins should show.
    int al_m   = 0;
    int abus_m = 0;
    int oe_m   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply controls, advance the model at the rising edge, check at the falling edge.
    task automatic cyc(input logic we, input logic inc, input logic dec, input logic lim,
                       input logic oe, input logic flt, input logic rst, input logic [15:0] val);
        int base;
        int d;
        reset          = rst;
        ctl_al_we      = we;
        ctl_inc_cy     = inc;
        ctl_inc_dec    = dec;
        ctl_inc_limit7 = lim;
        ctl_al_oe      = oe;
        ctl_bus_float  = flt;
        tb_val         = val;
        tb_drv         = !oe;
        @(posedge clk);
        if (rst) begin
            al_m   = 0;
            abus_m = 0;
            oe_m   = 0;
        end else begin
            base = (we && !oe) ? int'(val) : al_m;
            d    = dec ? -1 : 1;
            abus_m = al_m;
            if (!inc)
                al_m = base;
            else if (lim)
                al_m = (base / 128) * 128 + ((base % 128) + d + 128) % 128;
            else
                al_m = (base + d + 65536) % 65536;
            oe_m = flt ? 0 : 1;
        end
        @(negedge clk);
        check("abus", abus, 16'(abus_m));
        check("abus_oe", {15'd0, abus_oe}, 16'(oe_m));
        check("al_nz", {15'd0, al_nz}, (al_m != 0) ? 16'd1 : 16'd0);
        if (oe)
            check("bus_wb", {db_hi_as, db_lo_as}, 16'(al_m));
        else
            check("bus_ext", {db_hi_as, db_lo_as}, val);
    endtask

    // Idle cycle with the latch driving the bus so al is observed directly.
    task automatic show();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        logic [15:0] pick;
        logic [15:0] edges [4];
        edges[0] = 16'h0000; edges[1] = 16'hFFFF; edges[2] = 16'h007F; edges[3] = 16'h0080;

        // Reset and release.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Capture with increment, then write-back.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
        show();
        show();

        // Wrap both ways.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        show();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        show();

        // Block-transfer count down.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        show();

        // Limit7 cases.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h347F);
        show();
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h34FF);
        show();
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080);
        show();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Write enable masked while driving; increment still applies.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5555);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5555);

        // Float for three cycles.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2222);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4444);

        // Reset overrides an active capture and increment.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        show();

        // Random traffic, biased toward boundary values.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) pick = edges[$urandom_range(0, 3)];
            else                          pick = 16'($urandom);
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 29) == 0, pick);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
